// File: rtl/ls_buffer_if.sv
// Bundle of all decoder/ROB, CDB and memory-controller signals of the load/store buffer.
// The slave side is the buffer itself; the master side is whoever drives the buffer.
interface ls_buffer_if #(
  parameter int ROB_W  = 4,
  parameter int DATA_W = 32
);
  logic              in_flush;
  logic              in_valid;
  logic [ROB_W-1:0]  in_rob_tag;
  logic              in_is_store;
  logic [1:0]        in_width;
  logic              in_signed;
  logic [DATA_W-1:0] in_imm;
  logic [ROB_W-1:0]  in_base_tag;
  logic [DATA_W-1:0] in_base_val;
  logic [ROB_W-1:0]  in_data_tag;
  logic [DATA_W-1:0] in_data_val;
  logic              out_full;
  logic [ROB_W-1:0]  in_cdb_tag;
  logic [DATA_W-1:0] in_cdb_value;
  logic [ROB_W-1:0]  in_commit_tag;
  logic              out_mem_req;
  logic              out_mem_we;
  logic [DATA_W-1:0] out_mem_addr;
  logic [DATA_W-1:0] out_mem_wdata;
  logic [1:0]        out_mem_width;
  logic              in_mem_done;
  logic [DATA_W-1:0] in_mem_rdata;
  logic [ROB_W-1:0]  out_ls_tag;
  logic [DATA_W-1:0] out_ls_value;

  modport master (
    output in_flush, in_valid, in_rob_tag, in_is_store, in_width, in_signed, in_imm,
           in_base_tag, in_base_val, in_data_tag, in_data_val, in_cdb_tag, in_cdb_value,
           in_commit_tag, in_mem_done, in_mem_rdata,
    input  out_full, out_mem_req, out_mem_we, out_mem_addr, out_mem_wdata, out_mem_width,
           out_ls_tag, out_ls_value
  );

  modport slave (
    input  in_flush, in_valid, in_rob_tag, in_is_store, in_width, in_signed, in_imm,
           in_base_tag, in_base_val, in_data_tag, in_data_val, in_cdb_tag, in_cdb_value,
           in_commit_tag, in_mem_done, in_mem_rdata,
    output out_full, out_mem_req, out_mem_we, out_mem_addr, out_mem_wdata, out_mem_width,
           out_ls_tag, out_ls_value
  );
endinterface

// File: rtl/ls_buffer.sv
// In-order load/store buffer: snoops the ALU CDB for operands, issues the head entry to memory,
// broadcasts load results and store-ready notices, and keeps committed stores across a flush.
module ls_buffer #(
  parameter int LSB_SIZE = 8,
  parameter int ROB_W    = 4,
  parameter int DATA_W   = 32
) (
  input  logic        clk,
  input  logic        rst,
  ls_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(LSB_SIZE);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_reg;
  logic [PTR_W-1:0]    head_reg;
  logic [PTR_W-1:0]    tail_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                discard_reg;
  logic                busy_store_reg;

  logic [LSB_SIZE-1:0] valid_reg;
  logic [LSB_SIZE-1:0] store_reg;
  logic [LSB_SIZE-1:0] sgn_reg;
  logic [LSB_SIZE-1:0] committed_reg;
  logic [LSB_SIZE-1:0] notified_reg;
  logic [ROB_W-1:0]    tag_reg      [LSB_SIZE];
  logic [1:0]          width_reg    [LSB_SIZE];
  logic [DATA_W-1:0]   imm_reg      [LSB_SIZE];
  logic [ROB_W-1:0]    base_tag_reg [LSB_SIZE];
  logic [DATA_W-1:0]   base_val_reg [LSB_SIZE];
  logic [ROB_W-1:0]    data_tag_reg [LSB_SIZE];
  logic [DATA_W-1:0]   data_val_reg [LSB_SIZE];

  logic                mem_req_reg;
  logic                mem_we_reg;
  logic [DATA_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic [1:0]          mem_width_reg;
  logic [ROB_W-1:0]    ls_tag_reg;
  logic [DATA_W-1:0]   ls_value_reg;

  logic [LSB_SIZE-1:0] base_hit;
  logic [LSB_SIZE-1:0] data_hit;
  logic [LSB_SIZE-1:0] commit_hit;
  logic [LSB_SIZE-1:0] ready;
  logic [PTR_W-1:0]    age [LSB_SIZE];

  logic                full;
  logic                alloc;
  logic                retire;
  logic                issue_ok;
  logic                load_result;
  logic                busy_load;
  logic                notice_found;
  logic [PTR_W-1:0]    notice_idx;
  logic [CNT_W-1:0]    keep_cnt;
  logic [CNT_W-1:0]    keep_final;
  logic [ROB_W-1:0]    alloc_base_tag;
  logic [DATA_W-1:0]   alloc_base_val;
  logic [ROB_W-1:0]    alloc_data_tag;
  logic [DATA_W-1:0]   alloc_data_val;

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                               input logic [1:0] width,
                                               input logic sgn);
    case (width)
      2'd0:    extend = {{(DATA_W-8){sgn & raw[7]}}, raw[7:0]};
      2'd1:    extend = {{(DATA_W-16){sgn & raw[15]}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  generate
    for (genvar gi = 0; gi < LSB_SIZE; gi++) begin : g_entry
      assign base_hit[gi]   = valid_reg[gi] && (bus.in_cdb_tag != '0) &&
                              (base_tag_reg[gi] == bus.in_cdb_tag);
      assign data_hit[gi]   = valid_reg[gi] && (bus.in_cdb_tag != '0) &&
                              (data_tag_reg[gi] == bus.in_cdb_tag);
      assign commit_hit[gi] = valid_reg[gi] && (bus.in_commit_tag != '0) &&
                              (tag_reg[gi] == bus.in_commit_tag);
      assign ready[gi]      = (base_tag_reg[gi] == '0) && (data_tag_reg[gi] == '0);
      assign age[gi]        = PTR_W'(gi) - head_reg;
    end
  endgenerate

  assign full      = (count_reg == CNT_W'(LSB_SIZE));
  assign alloc     = bus.in_valid && !full && !bus.in_flush;
  assign retire    = (state_reg == BUSY) && bus.in_mem_done;
  assign busy_load = (state_reg == BUSY) && !busy_store_reg;
  assign load_result = retire && !busy_store_reg && !discard_reg;

  // Loads wait only on the base; stores need the ROB commit, which implies ready operands.
  assign issue_ok = (state_reg == IDLE) && valid_reg[head_reg] &&
                    (store_reg[head_reg] ? committed_reg[head_reg]
                                         : (base_tag_reg[head_reg] == '0) && !bus.in_flush);

  // A new op may name the tag being broadcast right now; take the value directly.
  always_comb begin
    alloc_base_tag = bus.in_base_tag;
    alloc_base_val = bus.in_base_val;
    alloc_data_tag = bus.in_data_tag;
    alloc_data_val = bus.in_data_val;
    if (bus.in_cdb_tag != '0 && bus.in_base_tag == bus.in_cdb_tag) begin
      alloc_base_tag = '0;
      alloc_base_val = bus.in_cdb_value;
    end
    if (bus.in_cdb_tag != '0 && bus.in_data_tag == bus.in_cdb_tag) begin
      alloc_data_tag = '0;
      alloc_data_val = bus.in_cdb_value;
    end
  end

  // Age-ordered scan: oldest un-notified ready store, and the committed run from head.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             run;
    notice_found = 1'b0;
    notice_idx   = '0;
    keep_cnt     = '0;
    run          = 1'b1;
    idx          = '0;
    for (int a = 0; a < LSB_SIZE; a++) begin
      idx = head_reg + PTR_W'(a);
      if (!notice_found && valid_reg[idx] && store_reg[idx] && ready[idx] && !notified_reg[idx]) begin
        notice_found = 1'b1;
        notice_idx   = idx;
      end
      if (run && valid_reg[idx] && (committed_reg[idx] || commit_hit[idx]))
        keep_cnt = keep_cnt + CNT_W'(1);
      else
        run = 1'b0;
    end
    keep_final = busy_load ? CNT_W'(1) : keep_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      discard_reg    <= 1'b0;
      busy_store_reg <= 1'b0;
      valid_reg      <= '0;
      committed_reg  <= '0;
      notified_reg   <= '0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_width_reg  <= '0;
      ls_tag_reg     <= '0;
      ls_value_reg   <= '0;
    end else begin
      mem_req_reg  <= 1'b0;
      ls_tag_reg   <= '0;
      ls_value_reg <= '0;

      for (int i = 0; i < LSB_SIZE; i++) begin
        if (base_hit[i]) begin
          base_tag_reg[i] <= '0;
          base_val_reg[i] <= bus.in_cdb_value;
        end
        if (data_hit[i]) begin
          data_tag_reg[i] <= '0;
          data_val_reg[i] <= bus.in_cdb_value;
        end
        if (commit_hit[i])
          committed_reg[i] <= 1'b1;
      end

      if (notice_found && !load_result && !bus.in_flush) begin
        ls_tag_reg                <= tag_reg[notice_idx];
        notified_reg[notice_idx]  <= 1'b1;
      end

      if (retire) begin
        valid_reg[head_reg]     <= 1'b0;
        committed_reg[head_reg] <= 1'b0;
        notified_reg[head_reg]  <= 1'b0;
        head_reg                <= head_reg + PTR_W'(1);
        state_reg               <= IDLE;
        discard_reg             <= 1'b0;
        if (load_result) begin
          ls_tag_reg   <= tag_reg[head_reg];
          ls_value_reg <= extend(bus.in_mem_rdata, width_reg[head_reg], sgn_reg[head_reg]);
        end
      end

      if (issue_ok) begin
        state_reg      <= BUSY;
        mem_req_reg    <= 1'b1;
        mem_we_reg     <= store_reg[head_reg];
        mem_addr_reg   <= base_val_reg[head_reg] + imm_reg[head_reg];
        mem_wdata_reg  <= data_val_reg[head_reg];
        mem_width_reg  <= width_reg[head_reg];
        busy_store_reg <= store_reg[head_reg];
      end

      if (alloc) begin
        valid_reg[tail_reg]     <= 1'b1;
        store_reg[tail_reg]     <= bus.in_is_store;
        sgn_reg[tail_reg]       <= bus.in_signed;
        committed_reg[tail_reg] <= 1'b0;
        notified_reg[tail_reg]  <= 1'b0;
        tag_reg[tail_reg]       <= bus.in_rob_tag;
        width_reg[tail_reg]     <= bus.in_width;
        imm_reg[tail_reg]       <= bus.in_imm;
        base_tag_reg[tail_reg]  <= alloc_base_tag;
        base_val_reg[tail_reg]  <= alloc_base_val;
        data_tag_reg[tail_reg]  <= alloc_data_tag;
        data_val_reg[tail_reg]  <= alloc_data_val;
        tail_reg                <= tail_reg + PTR_W'(1);
      end

      count_reg <= count_reg + CNT_W'(alloc) - CNT_W'(retire);

      // Keep the committed run (or the in-flight load, retired silently later); drop the rest.
      if (bus.in_flush) begin
        for (int i = 0; i < LSB_SIZE; i++) begin
          if ({1'b0, age[i]} >= keep_final)
            valid_reg[i] <= 1'b0;
        end
        tail_reg     <= head_reg + keep_final[PTR_W-1:0];
        count_reg    <= keep_final - CNT_W'(retire);
        ls_tag_reg   <= '0;
        ls_value_reg <= '0;
        if (busy_load && !retire)
          discard_reg <= 1'b1;
      end
    end
  end

  assign bus.out_full      = full;
  assign bus.out_mem_req   = mem_req_reg;
  assign bus.out_mem_we    = mem_we_reg;
  assign bus.out_mem_addr  = mem_addr_reg;
  assign bus.out_mem_wdata = mem_wdata_reg;
  assign bus.out_mem_width = mem_width_reg;
  assign bus.out_ls_tag    = ls_tag_reg;
  assign bus.out_ls_value  = ls_value_reg;
endmodule

// File: tb/tb_ls_buffer.sv
// Directed bench for ls_buffer: a table of single-load vectors plus hand-written
// store, full, flush and reset sequences, each comparison against hand-computed values.
module tb_ls_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ls_buffer_if #(.ROB_W(4), .DATA_W(32)) bus ();

  ls_buffer #(.LSB_SIZE(8), .ROB_W(4), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [1:0]  width;
    logic        sgn;
    logic        bypass;
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_value;
  } load_vec_t;

  load_vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic clear_inputs();
    bus.in_flush      = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_rob_tag    = '0;
    bus.in_is_store   = 1'b0;
    bus.in_width      = 2'd2;
    bus.in_signed     = 1'b0;
    bus.in_imm        = '0;
    bus.in_base_tag   = '0;
    bus.in_base_val   = '0;
    bus.in_data_tag   = '0;
    bus.in_data_val   = '0;
    bus.in_cdb_tag    = '0;
    bus.in_cdb_value  = '0;
    bus.in_commit_tag = '0;
    bus.in_mem_done   = 1'b0;
    bus.in_mem_rdata  = '0;
  endtask

  // Drives one allocation for the next edge; caller steps.
  task automatic set_alloc(input logic [3:0] tag, input logic st, input logic [1:0] w,
                           input logic sgn, input logic [31:0] imm,
                           input logic [3:0] btag, input logic [31:0] bval,
                           input logic [3:0] dtag, input logic [31:0] dval);
    bus.in_valid    = 1'b1;
    bus.in_rob_tag  = tag;
    bus.in_is_store = st;
    bus.in_width    = w;
    bus.in_signed   = sgn;
    bus.in_imm      = imm;
    bus.in_base_tag = btag;
    bus.in_base_val = bval;
    bus.in_data_tag = dtag;
    bus.in_data_val = dval;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (bus.out_mem_req) ok = 1'b1;
      else step();
    end
  endtask

  task automatic run_load(input load_vec_t v);
    bit ok;
    set_alloc(v.tag, 1'b0, v.width, v.sgn, v.imm, v.bypass ? 4'd7 : 4'd0,
              v.bypass ? 32'hBAD0BAD0 : v.base, 4'd0, 32'd0);
    if (v.bypass) begin
      bus.in_cdb_tag   = 4'd7;
      bus.in_cdb_value = v.base;
    end
    step();
    bus.in_valid   = 1'b0;
    bus.in_cdb_tag = '0;
    wait_req(ok);
    check($sformatf("ld%0d req", v.tag), 32'(ok), 32'd1);
    check($sformatf("ld%0d addr", v.tag), bus.out_mem_addr, v.exp_addr);
    check($sformatf("ld%0d we/width", v.tag), {29'd0, bus.out_mem_we, bus.out_mem_width},
          {29'd0, 1'b0, v.width});
    bus.in_mem_done  = 1'b1;
    bus.in_mem_rdata = v.rdata;
    step();
    bus.in_mem_done  = 1'b0;
    check($sformatf("ld%0d req pulse", v.tag), 32'(bus.out_mem_req), 32'd0);
    check($sformatf("ld%0d tag", v.tag), 32'(bus.out_ls_tag), 32'(v.tag));
    check($sformatf("ld%0d value", v.tag), bus.out_ls_value, v.exp_value);
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    bit quiet;
    logic [3:0]  drain_tag  [8];
    logic [31:0] drain_addr [8];

    vecs[0] = '{4'd1, 2'd2, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0000_0104, 32'hDEAD_BEEF};
    vecs[1] = '{4'd2, 2'd0, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0001, 32'h0000_0080, 32'h0000_0201, 32'hFFFF_FF80};
    vecs[2] = '{4'd3, 2'd0, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0001, 32'h0000_0080, 32'h0000_0201, 32'h0000_0080};
    vecs[3] = '{4'd4, 2'd1, 1'b1, 1'b0, 32'h0000_1000, 32'hFFFF_FFFE, 32'h0000_8001, 32'h0000_0FFE, 32'hFFFF_8001};
    vecs[4] = '{4'd5, 2'd1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0000_0020, 32'h1234_8001, 32'h0000_0010, 32'h0000_8001};
    vecs[5] = '{4'd6, 2'd0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h00AB_CD7F, 32'h0000_0040, 32'h0000_007F};
    vecs[6] = '{4'd8, 2'd2, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0010, 32'h8000_0000, 32'h0000_0310, 32'h8000_0000};
    vecs[7] = '{4'd9, 2'd2, 1'b0, 1'b1, 32'h0000_0700, 32'h0000_0008, 32'h1357_9BDF, 32'h0000_0708, 32'h1357_9BDF};

    clear_inputs();
    repeat (3) step();
    rst = 1'b0;
    check("reset full/req/we", {29'd0, bus.out_full, bus.out_mem_req, bus.out_mem_we}, 32'd0);
    check("reset addr", bus.out_mem_addr, 32'd0);
    check("reset wdata", bus.out_mem_wdata, 32'd0);
    check("reset tag/width", {26'd0, bus.out_ls_tag, bus.out_mem_width}, 32'd0);
    check("reset value", bus.out_ls_value, 32'd0);

    for (int i = 0; i < 8; i++) run_load(vecs[i]);

    // Store waiting on data via CDB, notice, then commit-gated write.
    set_alloc(4'd2, 1'b1, 2'd2, 1'b0, 32'd0, 4'd0, 32'h400, 4'd3, 32'hBAD);
    step();
    bus.in_valid     = 1'b0;
    bus.in_cdb_tag   = 4'd3;
    bus.in_cdb_value = 32'h55;
    step();
    bus.in_cdb_tag   = '0;
    check("st notice early", 32'(bus.out_ls_tag), 32'd0);
    step();
    check("st notice tag", 32'(bus.out_ls_tag), 32'd2);
    check("st notice value", bus.out_ls_value, 32'd0);
    step();
    check("st notice once", 32'(bus.out_ls_tag), 32'd0);
    check("st no req before commit", 32'(bus.out_mem_req), 32'd0);
    bus.in_commit_tag = 4'd2;
    step();
    bus.in_commit_tag = '0;
    wait_req(ok);
    check("st req", 32'(ok), 32'd1);
    check("st we", 32'(bus.out_mem_we), 32'd1);
    check("st addr", bus.out_mem_addr, 32'h400);
    check("st wdata", bus.out_mem_wdata, 32'h55);
    bus.in_mem_done = 1'b1;
    step();
    bus.in_mem_done = 1'b0;
    check("st retire no tag", 32'(bus.out_ls_tag), 32'd0);

    // Fill with loads blocked on tag 9, then drain with a retire+alloc cycle.
    for (int i = 0; i < 8; i++) begin
      set_alloc(4'(i + 1), 1'b0, 2'd2, 1'b0, 32'(i * 4), 4'd9, 32'd0, 4'd0, 32'd0);
      step();
      if (i == 6) check("full at 7", 32'(bus.out_full), 32'd0);
    end
    check("full at 8", 32'(bus.out_full), 32'd1);
    set_alloc(4'd10, 1'b0, 2'd2, 1'b0, 32'd0, 4'd0, 32'hF00, 4'd0, 32'd0);
    step();
    bus.in_valid     = 1'b0;
    check("full 9th ignored", 32'(bus.out_full), 32'd1);
    bus.in_cdb_tag   = 4'd9;
    bus.in_cdb_value = 32'h1000;
    step();
    bus.in_cdb_tag   = '0;
    wait_req(ok);
    check("fill req1 addr", bus.out_mem_addr, ok ? 32'h1000 : 32'hFFFF_FFFF);
    set_alloc(4'd11, 1'b0, 2'd2, 1'b0, 32'h40, 4'd0, 32'h2000, 4'd0, 32'd0);
    bus.in_mem_done = 1'b1;
    step();
    bus.in_mem_done = 1'b0;
    bus.in_valid    = 1'b0;
    check("fill retire1 tag", 32'(bus.out_ls_tag), 32'd1);
    check("fill alloc-while-full dropped", 32'(bus.out_full), 32'd0);
    wait_req(ok);
    check("fill req2 addr", bus.out_mem_addr, ok ? 32'h1004 : 32'hFFFF_FFFF);
    set_alloc(4'd11, 1'b0, 2'd2, 1'b0, 32'h40, 4'd0, 32'h2000, 4'd0, 32'd0);
    bus.in_mem_done = 1'b1;
    step();
    bus.in_mem_done = 1'b0;
    check("fill retire2 tag", 32'(bus.out_ls_tag), 32'd2);
    check("fill alloc+retire count 7", 32'(bus.out_full), 32'd0);
    set_alloc(4'd12, 1'b0, 2'd2, 1'b0, 32'h44, 4'd0, 32'h2000, 4'd0, 32'd0);
    step();
    bus.in_valid = 1'b0;
    check("fill refull", 32'(bus.out_full), 32'd1);
    drain_tag  = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd11, 4'd12};
    drain_addr = '{32'h1008, 32'h100C, 32'h1010, 32'h1014, 32'h1018, 32'h101C, 32'h2040, 32'h2044};
    for (int i = 0; i < 8; i++) begin
      wait_req(ok);
      check($sformatf("drain%0d addr", i), bus.out_mem_addr, ok ? drain_addr[i] : 32'hFFFF_FFFF);
      bus.in_mem_done  = 1'b1;
      bus.in_mem_rdata = 32'(drain_tag[i]);
      step();
      bus.in_mem_done  = 1'b0;
      check($sformatf("drain%0d tag", i), 32'(bus.out_ls_tag), 32'(drain_tag[i]));
    end
    quiet = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      if (bus.out_mem_req) quiet = 1'b0;
    end
    check("drain no 9th entry", 32'(quiet), 32'd1);

    // Committed store survives a flush; younger loads vanish.
    set_alloc(4'd1, 1'b1, 2'd2, 1'b0, 32'd0, 4'd0, 32'h500, 4'd0, 32'h77);
    step();
    set_alloc(4'd2, 1'b0, 2'd2, 1'b0, 32'd0, 4'd0, 32'h10, 4'd0, 32'd0);
    bus.in_commit_tag = 4'd1;
    step();
    bus.in_commit_tag = '0;
    check("flush st notice", 32'(bus.out_ls_tag), 32'd1);
    set_alloc(4'd3, 1'b0, 2'd2, 1'b0, 32'd0, 4'd0, 32'h20, 4'd0, 32'd0);
    step();
    bus.in_valid = 1'b0;
    check("flush st req/we", {30'd0, bus.out_mem_req, bus.out_mem_we}, 32'd3);
    check("flush st wdata", bus.out_mem_wdata, 32'h77);
    bus.in_flush = 1'b1;
    step();
    bus.in_flush = 1'b0;
    check("flush tag forced 0", 32'(bus.out_ls_tag), 32'd0);
    bus.in_mem_done = 1'b1;
    step();
    bus.in_mem_done = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_mem_req || bus.out_ls_tag != 4'd0 || bus.out_full) quiet = 1'b0;
      step();
    end
    check("flush loads gone", 32'(quiet), 32'd1);

    // Flush while a load is in flight; its completion is swallowed.
    set_alloc(4'd4, 1'b0, 2'd2, 1'b0, 32'd0, 4'd0, 32'h30, 4'd0, 32'd0);
    step();
    bus.in_valid = 1'b0;
    wait_req(ok);
    check("disc req", 32'(ok), 32'd1);
    bus.in_flush = 1'b1;
    set_alloc(4'd9, 1'b0, 2'd2, 1'b0, 32'd0, 4'd0, 32'h90, 4'd0, 32'd0);
    step();
    bus.in_flush = 1'b0;
    bus.in_valid = 1'b0;
    check("disc flush tag", 32'(bus.out_ls_tag), 32'd0);
    bus.in_mem_done  = 1'b1;
    bus.in_mem_rdata = 32'h1234;
    step();
    bus.in_mem_done  = 1'b0;
    check("disc done silent", 32'(bus.out_ls_tag), 32'd0);
    quiet = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.out_mem_req || bus.out_ls_tag != 4'd0) quiet = 1'b0;
    end
    check("disc flush-cycle alloc ignored", 32'(quiet), 32'd1);
    run_load('{4'd5, 2'd2, 1'b0, 1'b0, 32'h600, 32'h8, 32'hCAFE_F00D, 32'h608, 32'hCAFE_F00D});

    // Reset mid-transaction; a late done is ignored.
    set_alloc(4'd6, 1'b0, 2'd2, 1'b0, 32'd0, 4'd0, 32'h800, 4'd0, 32'd0);
    step();
    bus.in_valid = 1'b0;
    wait_req(ok);
    check("rst req", 32'(ok), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst outputs", {27'd0, bus.out_full, bus.out_mem_req, bus.out_mem_we, bus.out_mem_width},
          32'd0);
    check("rst addr", bus.out_mem_addr, 32'd0);
    bus.in_mem_done  = 1'b1;
    bus.in_mem_rdata = 32'h5A5A;
    step();
    bus.in_mem_done  = 1'b0;
    check("rst late done", {27'd0, bus.out_mem_req, bus.out_ls_tag}, 32'd0);
    run_load(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
